lc_transition_frontend: RTL
===========================

LC_TRANSITION_FRONTEND -- requirements
Module: lc_transition_frontend

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 64, meaning cycles REQ may wait for lc_done (legal range 2..65535).
REQ-002 The block SHALL have parameter MAX_FAILS, default 3, meaning consecutive failed transitions before permanent lockout (legal range 1..15).
REQ-003 clk  input  1  clock; all logic rising-edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 word_valid  input  1  host identifier word valid.
REQ-006 word_data  input  32  host identifier word.
REQ-007 word_ready  output  1  block accepts word this cycle.
REQ-008 clear_req  input  1  discard partially loaded identifier.
REQ-009 lc_transition_request  output  1  request to lifecycle controller.
REQ-010 lc_identifier  output  256  assembled identifier to lifecycle controller.
REQ-011 lc_done  input  1  lifecycle controller finished.
REQ-012 lc_success  input  1  lifecycle transition accepted; sampled only with lc_done=1.
REQ-013 lc_state  input  3  current lifecycle state; 3'b101 = end of life.
REQ-014 resp_valid  output  1  one-cycle result strobe.
REQ-015 resp_ok  output  1  transition succeeded; meaningful only with resp_valid.
REQ-016 resp_timeout  output  1  no lc_done within TIMEOUT_CYCLES; meaningful only with resp_valid.
REQ-017 locked  output  1  lockout active.
REQ-018 fail_count  output  4  current consecutive-failure count.

Function
REQ-019 FSM states SHALL be COLLECT, REQ, RELEASE, RESP, LOCKED.
REQ-020 word_ready SHALL be 1 only in COLLECT with clear_req=0 and lc_state!=3'b101; a word is accepted when word_valid and word_ready are both 1.
REQ-021 Word k accepted (k=0..7) SHALL be stored at lc_identifier[255-32k -: 32] (first word = most significant).
REQ-022 A 3-bit word counter SHALL increment per accepted word; acceptance of word 7 SHALL move to REQ next cycle and reset the counter to 0.
REQ-023 clear_req=1 in COLLECT SHALL zero counter and identifier register; clear_req has priority over word acceptance; clear_req is ignored outside COLLECT.
REQ-024 lc_transition_request SHALL be 1 exactly while in REQ; lc_identifier SHALL stay stable throughout REQ and RELEASE.
REQ-025 In REQ a timer SHALL count from 0 each cycle; lc_done=1 SHALL latch lc_success into an ok flag, clear timeout flag, and go to RELEASE.
REQ-026 If timer equals TIMEOUT_CYCLES-1 with lc_done=0, the block SHALL set timeout flag, clear ok flag, and go to RELEASE; lc_done=1 on that same cycle wins (normal completion).
REQ-027 RELEASE SHALL hold request at 0 and go to RESP on the first cycle lc_done=0.
REQ-028 RESP SHALL last one cycle: resp_valid=1, resp_ok=ok flag, resp_timeout=timeout flag; identifier register SHALL be zeroed.
REQ-029 In RESP, ok SHALL clear fail_count to 0 and go to COLLECT; failure (reject or timeout) SHALL increment fail_count, going to LOCKED if the new value equals MAX_FAILS, else COLLECT.
REQ-030 LOCKED SHALL hold locked=1, word_ready=0, request=0; exit only by reset.
REQ-031 lc_state=3'b101 SHALL block new words but SHALL NOT abort a transition already in REQ/RELEASE.
REQ-032 resp_valid, resp_ok, resp_timeout SHALL be 0 in every state except RESP.

Reset
REQ-033 rst=0 SHALL immediately force: state COLLECT, counter 0, timer 0, identifier 0, fail_count 0, lc_transition_request 0, resp_valid 0, resp_ok 0, resp_timeout 0, locked 0.
REQ-034 Reset asserted mid-REQ SHALL drop lc_transition_request asynchronously; no response is produced for the aborted request.

Verification
REQ-035 Load words 0x00000001..0x00000008 back-to-back, lc_done=1/lc_success=1 two cycles after request -> lc_identifier=0x00000001_00000002_..._00000008, one resp_valid with resp_ok=1, fail_count=0.
REQ-036 Load 8 words, lc_done=1/lc_success=0 -> resp_ok=0, resp_timeout=0, fail_count=1; repeat twice more -> fail_count=3, locked=1, word_ready=0.
REQ-037 Load 8 words, hold lc_done=0 -> request high exactly 64 cycles, then resp_valid with resp_timeout=1, resp_ok=0, fail_count=1.
REQ-038 Load 3 words, pulse clear_req together with word_valid -> word dropped, counter 0; next 8 words form identifier from scratch.
REQ-039 lc_state=3'b101 with word_valid=1 -> word_ready=0, no request issued for 20 cycles.
REQ-040 lc_done held 1 for 5 cycles after success -> resp_valid only after lc_done falls; rst=0 during REQ -> request 0 same cycle, no resp_valid.

Source files
------------

// File: rtl/lc_transition_frontend.sv
// Host-facing front end for lifecycle transitions: collects a 256-bit identifier
// from eight 32-bit words, issues the request, reports the result and locks out after repeated failures.
module lc_transition_frontend #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned MAX_FAILS      = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         word_valid,
    input  logic [31:0]  word_data,
    output logic         word_ready,
    input  logic         clear_req,
    output logic         lc_transition_request,
    output logic [255:0] lc_identifier,
    input  logic         lc_done,
    input  logic         lc_success,
    input  logic [2:0]   lc_state,
    output logic         resp_valid,
    output logic         resp_ok,
    output logic         resp_timeout,
    output logic         locked,
    output logic [3:0]   fail_count
);

    typedef enum logic [2:0] {
        COLLECT,
        REQ,
        RELEASE,
        RESP,
        LOCKED
    } state_e;

    localparam logic [2:0]  EndOfLife = 3'b101;
    localparam logic [15:0] TimerLast = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]  FailLimit = 4'(MAX_FAILS);

    state_e         state_q;
    logic [2:0]     wordCount_q;
    logic [15:0]    timer_q;
    logic [255:0]   ident_q;
    logic           okFlag_q;
    logic           timeoutFlag_q;
    logic [3:0]     failCount_q;
    logic           req_q;
    logic           respValid_q;
    logic           respOk_q;
    logic           respTimeout_q;
    logic           locked_q;
    logic           wordAccept;

    // Words are only taken while collecting, not being cleared, and not at end of life.
    always_comb begin
        word_ready = (state_q == COLLECT) && !clear_req && (lc_state != EndOfLife);
        wordAccept = word_valid && word_ready;
    end

    // Single FSM; all handshake and response outputs are registered here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= COLLECT;
            wordCount_q   <= 3'd0;
            timer_q       <= 16'd0;
            ident_q       <= '0;
            okFlag_q      <= 1'b0;
            timeoutFlag_q <= 1'b0;
            failCount_q   <= 4'd0;
            req_q         <= 1'b0;
            respValid_q   <= 1'b0;
            respOk_q      <= 1'b0;
            respTimeout_q <= 1'b0;
            locked_q      <= 1'b0;
        end else begin
            unique case (state_q)
                COLLECT: begin
                    if (clear_req) begin
                        wordCount_q <= 3'd0;
                        ident_q     <= '0;
                    end else if (wordAccept) begin
                        // First word lands in the most significant slot.
                        ident_q[{~wordCount_q, 5'd0} +: 32] <= word_data;
                        if (wordCount_q == 3'd7) begin
                            wordCount_q <= 3'd0;
                            timer_q     <= 16'd0;
                            req_q       <= 1'b1;
                            state_q     <= REQ;
                        end else begin
                            wordCount_q <= wordCount_q + 3'd1;
                        end
                    end
                end
                REQ: begin
                    // A completion arriving on the last timer cycle still counts as normal.
                    if (lc_done) begin
                        okFlag_q      <= lc_success;
                        timeoutFlag_q <= 1'b0;
                        req_q         <= 1'b0;
                        state_q       <= RELEASE;
                    end else if (timer_q == TimerLast) begin
                        okFlag_q      <= 1'b0;
                        timeoutFlag_q <= 1'b1;
                        req_q         <= 1'b0;
                        state_q       <= RELEASE;
                    end else begin
                        timer_q <= timer_q + 16'd1;
                    end
                end
                RELEASE: begin
                    if (!lc_done) begin
                        respValid_q   <= 1'b1;
                        respOk_q      <= okFlag_q;
                        respTimeout_q <= timeoutFlag_q;
                        state_q       <= RESP;
                    end
                end
                RESP: begin
                    respValid_q   <= 1'b0;
                    respOk_q      <= 1'b0;
                    respTimeout_q <= 1'b0;
                    ident_q       <= '0;
                    if (okFlag_q) begin
                        failCount_q <= 4'd0;
                        state_q     <= COLLECT;
                    end else begin
                        failCount_q <= failCount_q + 4'd1;
                        if (failCount_q + 4'd1 == FailLimit) begin
                            locked_q <= 1'b1;
                            state_q  <= LOCKED;
                        end else begin
                            state_q <= COLLECT;
                        end
                    end
                end
                LOCKED: begin
                    locked_q <= 1'b1;
                end
                default: begin
                    state_q <= COLLECT;
                end
            endcase
        end
    end

    assign lc_transition_request = req_q;
    assign lc_identifier         = ident_q;
    assign resp_valid            = respValid_q;
    assign resp_ok               = respOk_q;
    assign resp_timeout          = respTimeout_q;
    assign locked                = locked_q;
    assign fail_count            = failCount_q;

endmodule
